// File: rtl/crc_serial_engine.sv
// Bit-serial MSB-first CRC: start -> LOAD -> DATA_W SHIFT cycles -> one-cycle o_done (DATA_W+2 edges after start).
// No backpressure: a start while busy is dropped and recorded in the sticky o_ovr flag.
module crc_serial_engine #(
    parameter int               DATA_W = 32,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOROUT = 16'h0000
) (
    input  logic              s_clk,
    input  logic              srst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clr_ovr,
    output logic              o_busy,
    output logic              o_done,
    output logic [CRC_W-1:0]  o_crc,
    output logic              o_ovr
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_out_q, crc_out_d;
    logic               ovr_q, ovr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fb;
    logic [CRC_W-1:0]   crc_step;

    always_ff @(posedge s_clk) begin
        if (srst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            crc_q     <= '0;
            cnt_q     <= '0;
            crc_out_q <= '0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            crc_out_q <= crc_out_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One LFSR step: the message bit enters at the top of the CRC register.
    assign fb       = crc_q[CRC_W-1] ^ shift_q[DATA_W-1];
    assign crc_step = (crc_q << 1) ^ (fb ? POLY : '0);

    always_comb begin
        shift_d   = shift_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        crc_out_d = crc_out_q;
        case (state_q)
            S_LOAD: begin
                shift_d = i_data;
                crc_d   = INIT;
                cnt_d   = CNT_LAST;
            end
            S_SHIFT: begin
                shift_d = shift_q << 1;
                crc_d   = crc_step;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) crc_out_d = crc_step ^ XOROUT;
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        ovr_d  = ovr_q;
        if (i_clr_ovr) ovr_d = 1'b0;
        if (i_start && (state_q != S_IDLE)) ovr_d = 1'b1;
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_crc  = crc_out_q;
    assign o_ovr  = ovr_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: an 8-bit and a 72-bit instance, scoreboard of expected CRCs popped on o_done.
module tb_crc_serial_engine;
    logic        clk = 1'b0;
    logic        srst;
    logic        st8, clr8, busy8, done8, ovr8;
    logic [7:0]  dat8;
    logic [15:0] crc8;
    logic        st72, clr72, busy72, done72, ovr72;
    logic [71:0] dat72;
    logic [15:0] crc72;

    int checks = 0;
    int fails  = 0;
    int done8_n = 0;
    int n0;
    int found;
    logic [15:0] sb8[$];
    logic [15:0] sb72[$];
    logic [15:0] e8, e72;

    typedef struct {
        logic [7:0]  d;
        logic [15:0] e;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    crc_serial_engine #(.DATA_W(8)) dut8 (
        .s_clk(clk), .srst(srst), .i_start(st8), .i_data(dat8), .i_clr_ovr(clr8),
        .o_busy(busy8), .o_done(done8), .o_crc(crc8), .o_ovr(ovr8)
    );

    crc_serial_engine #(.DATA_W(72)) dut72 (
        .s_clk(clk), .srst(srst), .i_start(st72), .i_data(dat72), .i_clr_ovr(clr72),
        .o_busy(busy72), .o_done(done72), .o_crc(crc72), .o_ovr(ovr72)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte-at-a-time software formulation of CRC-16/CCITT-FALSE.
    function automatic logic [15:0] ref_crc(input logic [7:0] b);
        logic [15:0] c;
        c = 16'hFFFF ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done8_n++;
            if (sb8.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_done8 actual=1 required=0");
            end else begin
                e8 = sb8.pop_front();
                chk("crc8", {56'd0, crc8}, {56'd0, e8});
            end
        end
        if (done72 === 1'b1) begin
            if (sb72.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_done72 actual=1 required=0");
            end else begin
                e72 = sb72.pop_front();
                chk("crc72", {56'd0, crc72}, {56'd0, e72});
            end
        end
    end

    // Start one 8-bit op and check busy/done cycle by cycle relative to the sampling edge.
    task automatic run8(input logic [7:0] d, input logic [15:0] e);
        st8 = 1'b1; dat8 = d; sb8.push_back(e);
        tick();
        st8 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("busy8_k%0d", k), {71'd0, busy8}, {71'd0, (k <= 9)});
            chk($sformatf("done8_k%0d", k), {71'd0, done8}, {71'd0, (k == 9)});
            tick();
        end
    endtask

    initial begin
        srst = 1'b1; st8 = 0; dat8 = '0; clr8 = 0; st72 = 0; dat72 = '0; clr72 = 0;
        tbl[0] = '{8'h00, 16'hE1F0};
        tbl[1] = '{8'hFF, ref_crc(8'hFF)};
        tbl[2] = '{8'h31, ref_crc(8'h31)};
        tbl[3] = '{8'hA5, ref_crc(8'hA5)};
        tbl[4] = '{8'h80, ref_crc(8'h80)};
        tick(); tick();
        chk("rst_busy", {71'd0, busy8}, 72'd0);
        chk("rst_done", {71'd0, done8}, 72'd0);
        chk("rst_crc",  {56'd0, crc8},  72'd0);
        chk("rst_ovr",  {71'd0, ovr8},  72'd0);
        chk("rst_crc72", {56'd0, crc72}, 72'd0);
        srst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run8(tbl[i].d, tbl[i].e);
        chk("table_done_count", done8_n, 5);

        // Overrun during SHIFT, then a clear/set collision, then a lone clear.
        n0 = done8_n;
        st8 = 1'b1; dat8 = 8'h00; sb8.push_back(16'hE1F0);
        tick(); st8 = 1'b0;
        repeat (3) tick();
        chk("ovr_before", {71'd0, ovr8}, 72'd0);
        st8 = 1'b1;
        tick();
        chk("ovr_set", {71'd0, ovr8}, 72'd1);
        clr8 = 1'b1;
        tick();
        chk("ovr_collision", {71'd0, ovr8}, 72'd1);
        st8 = 1'b0;
        tick();
        chk("ovr_cleared", {71'd0, ovr8}, 72'd0);
        clr8 = 1'b0;
        repeat (6) tick();
        chk("ovr_one_done", done8_n - n0, 1);
        chk("ovr_busy_end", {71'd0, busy8}, 72'd0);

        // Back-to-back at minimum spacing, with i_data changing during SHIFT.
        n0 = done8_n;
        st8 = 1'b1; dat8 = 8'h00; sb8.push_back(16'hE1F0);
        tick(); st8 = 1'b0;
        repeat (10) tick();
        chk("crc_hold_idle", {56'd0, crc8}, 72'h0E1F0);
        st8 = 1'b1; dat8 = 8'hA5; sb8.push_back(ref_crc(8'hA5));
        tick(); st8 = 1'b0;
        chk("b2b_no_ovr", {71'd0, ovr8}, 72'd0);
        tick();
        dat8 = 8'h3C;
        repeat (3) tick();
        chk("crc_hold_busy", {56'd0, crc8}, 72'h0E1F0);
        repeat (8) tick();
        chk("b2b_done_count", done8_n - n0, 2);

        // Reset mid-SHIFT with a pending overrun; a start during reset is discarded.
        n0 = done8_n;
        st8 = 1'b1; dat8 = 8'h5A; sb8.push_back(ref_crc(8'h5A));
        tick(); st8 = 1'b0;
        repeat (2) tick();
        st8 = 1'b1;
        tick(); st8 = 1'b0;
        chk("ovr_pre_rst", {71'd0, ovr8}, 72'd1);
        tick();
        srst = 1'b1; sb8.delete();
        tick(); tick();
        st8 = 1'b1;
        tick();
        st8 = 1'b0; srst = 1'b0;
        chk("mid_rst_busy", {71'd0, busy8}, 72'd0);
        chk("mid_rst_done", {71'd0, done8}, 72'd0);
        chk("mid_rst_crc",  {56'd0, crc8},  72'd0);
        chk("mid_rst_ovr",  {71'd0, ovr8},  72'd0);
        tick();
        chk("rst_start_dropped", {71'd0, busy8}, 72'd0);
        repeat (15) tick();
        chk("no_done_after_rst", done8_n - n0, 0);

        // "123456789" check string on the 72-bit instance.
        st72 = 1'b1; dat72 = 72'h313233343536373839; sb72.push_back(16'h29B1);
        tick(); st72 = 1'b0;
        found = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done72 === 1'b1 && found < 0) found = i;
        end
        chk("done72_latency", found, 73);
        chk("busy72_end", {71'd0, busy72}, 72'd0);

        chk("sb8_drained",  sb8.size(),  0);
        chk("sb72_drained", sb72.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
